// File: rtl/ysyx_24100027_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode handshake,
// next-PC input and status outputs. master = fetch unit, slave = its environment.
interface ysyx_24100027_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               fetch_fault, fetch_cnt,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               inst_ready, npc_valid, npc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               fetch_fault, fetch_cnt,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
               inst_ready, npc_valid, npc
    );
endinterface

// File: rtl/ysyx_24100027_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, issues one memory read at a
// time, hands the word to decode and waits for the next PC before refetching.
module ysyx_24100027_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ysyx_24100027_ifu_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_NPC   = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        req_valid_q, req_valid_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fault_q, fault_d;

    // Next-state, datapath updates and output flags derived from the next state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (bus.imem_resp_err) begin
                        state_d = S_FAULT;
                    end else begin
                        inst_d    = bus.imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = S_OUT;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUT: begin
                if (bus.inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_NPC;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_NPC: begin
                // A misaligned target is a fault; the PC keeps the faulting instruction's address
                if (bus.npc_valid) begin
                    if (bus.npc[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = bus.npc;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_NPC;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_valid_d  = (state_d == S_REQ);
        inst_valid_d = (state_d == S_OUT);
        fault_d      = (state_d == S_FAULT);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            fetch_cnt_q  <= 32'h0000_0000;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_fault    = fault_q;
    assign bus.fetch_cnt      = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_24100027_ifu.sv
// Directed-plus-random bench for the fetch unit; expectations come from a
// transaction-level model (expected PC, delivered count, fault flag, memory image).
module tb_ysyx_24100027_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_fault;

    ysyx_24100027_ifu_if bus ();

    ysyx_24100027_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Memory image seen by the bench: fixed word at the reset vector, hash elsewhere
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0413;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0000_0000;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.npc_valid       = 1'b0;
        bus.npc             = 32'h0000_0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
        chk("rst_addr", bus.imem_req_addr, RESET_PC);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_cnt", bus.fetch_cnt, 32'd0);
        rst_n = 1'b1;
        step();
        exp_pc    = RESET_PC;
        exp_cnt   = 32'd0;
        exp_fault = 1'b0;
        chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("first_req_addr", bus.imem_req_addr, RESET_PC);
    endtask

    // One full fetch transaction starting with the unit presenting a request
    task automatic do_fetch(input int req_dly, input int resp_dly, input int dec_dly,
                            input int npc_dly, input logic [31:0] next_pc, input logic err);
        logic [31:0] word;
        word = memword(exp_pc);
        chk("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("req_addr", bus.imem_req_addr, exp_pc);
        for (int i = 0; i < req_dly; i++) begin
            bus.imem_req_ready  = 1'b0;
            bus.imem_resp_valid = (i == 0);
            bus.imem_resp_data  = $urandom;
            step();
            chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            chk("stall_req_addr", bus.imem_req_addr, exp_pc);
            chk("stall_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        end
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready  = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("wait_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        for (int i = 0; i < resp_dly; i++) begin
            bus.imem_req_ready = 1'b1;
            step();
            bus.imem_req_ready = 1'b0;
            chk("wait_hold_req", {31'd0, bus.imem_req_valid}, 32'd0);
            chk("wait_hold_inst", {31'd0, bus.inst_valid}, 32'd0);
        end
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word;
        bus.imem_resp_err   = err;
        step();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        if (err) begin
            exp_fault = 1'b1;
            chk("err_fault", {31'd0, bus.fetch_fault}, 32'd1);
            chk("err_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            chk("err_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            return;
        end
        chk("out_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("out_inst", bus.inst, word);
        chk("out_pc", bus.inst_pc, exp_pc);
        chk("out_cnt", bus.fetch_cnt, exp_cnt);
        for (int i = 0; i < dec_dly; i++) begin
            bus.npc_valid       = 1'b1;
            bus.npc             = $urandom;
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = $urandom;
            step();
            chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("bp_inst", bus.inst, word);
            chk("bp_pc", bus.inst_pc, exp_pc);
            chk("bp_cnt", bus.fetch_cnt, exp_cnt);
        end
        bus.npc_valid       = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.inst_ready      = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        chk("hs_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("hs_cnt", bus.fetch_cnt, exp_cnt);
        for (int i = 0; i < npc_dly; i++) begin
            step();
            chk("npc_wait_req", {31'd0, bus.imem_req_valid}, 32'd0);
        end
        bus.npc_valid = 1'b1;
        bus.npc       = next_pc;
        step();
        bus.npc_valid = 1'b0;
        if (next_pc[1:0] != 2'b00) begin
            exp_fault = 1'b1;
            chk("npc_fault", {31'd0, bus.fetch_fault}, 32'd1);
            chk("npc_fault_req", {31'd0, bus.imem_req_valid}, 32'd0);
            chk("npc_fault_pc", bus.imem_req_addr, exp_pc);
        end else begin
            exp_pc = next_pc;
            chk("next_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            chk("next_req_addr", bus.imem_req_addr, exp_pc);
        end
    endtask

    // The unit must stay parked in the fault state whatever the environment does
    task automatic fault_hold();
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.inst_ready      = 1'b1;
        bus.npc_valid       = 1'b1;
        bus.npc             = RESET_PC + 32'd16;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fh_fault", {31'd0, bus.fetch_fault}, {31'd0, exp_fault});
            chk("fh_req", {31'd0, bus.imem_req_valid}, 32'd0);
            chk("fh_inst", {31'd0, bus.inst_valid}, 32'd0);
            chk("fh_cnt", bus.fetch_cnt, exp_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] target;
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        idle_inputs();
        step();
        do_reset();

        do_fetch(0, 0, 0, 0, 32'h8000_0004, 1'b0);
        chk("cnt_after_first", bus.fetch_cnt, 32'd1);

        do_fetch(3, 1, 5, 2, exp_pc, 1'b0);

        for (int n = 0; n < 20; n++) begin
            r = $urandom;
            target = {exp_pc[31:12], r[9:0], 2'b00};
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), target, 1'b0);
        end

        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        do_fetch(0, 0, 0, 0, exp_pc + 32'd4, 1'b0);
        chk("cnt_wrap", bus.fetch_cnt, 32'd0);

        do_fetch(1, 0, 0, 0, 32'h8000_0006, 1'b0);
        fault_hold();

        do_reset();
        do_fetch(0, 0, 0, 0, 32'h8000_0008, 1'b0);
        do_fetch(0, 2, 0, 0, 32'h8000_000C, 1'b1);
        fault_hold();

        do_reset();
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk("pre_rst_wait", {31'd0, bus.imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        step();
        step();
        bus.imem_resp_valid = 1'b0;
        exp_pc  = RESET_PC;
        exp_cnt = 32'd0;
        chk("late_resp_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("late_resp_inst", bus.inst, 32'd0);
        do_fetch(0, 0, 0, 0, 32'h8000_0004, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_24100027_ifu.md
# ysyx_24100027_ifu

Instruction fetch unit of the NPC multi-cycle core, sitting directly upstream of the instruction decode stage. It owns the architectural PC, issues one instruction-memory read at a time through a valid/ready request channel, registers the returned word, and presents it with its PC to decode under a valid/ready handshake. It then waits for the next PC from the execute/writeback path before fetching again. It also reports fetch faults and counts delivered instructions.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  read address; always equals pc
- imem_resp_valid  input  1  read data valid
- imem_resp_data  input  32  instruction word
- imem_resp_err  input  1  access error, qualified by imem_resp_valid
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  32  registered instruction word
- inst_pc  output  32  PC of inst
- npc_valid  input  1  next PC valid (retire of current instruction)
- npc  input  32  next PC value
- fetch_fault  output  1  sticky fault flag
- fetch_cnt  output  32  instructions delivered to decode

## Operation
- States: IDLE, REQ, WAIT, OUT, NPC, FAULT. All outputs Moore (decoded from state/registers only).
- IDLE: entered on reset; unconditional transition to REQ next cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_valid && imem_req_ready -> WAIT. Address held stable while ready is low.
- WAIT: on imem_resp_valid: if imem_resp_err -> FAULT; else inst<=imem_resp_data, inst_pc<=pc -> OUT.
- OUT: inst_valid=1; inst, inst_pc stable. On inst_ready -> NPC, fetch_cnt<=fetch_cnt+1 (wraps 32'hFFFF_FFFF -> 0).
- NPC: on npc_valid: if npc[1:0]!=0 -> FAULT (pc unchanged); else pc<=npc -> REQ.
- FAULT: terminal until reset; fetch_fault=1, imem_req_valid=0, inst_valid=0.
- imem_resp_valid outside WAIT and npc_valid outside NPC are ignored (no state, pc or inst change).
- Exactly one outstanding memory request at any time.
- npc equal to current pc is legal (self-loop): refetches same address.

## Timing
- Reset (rst_n low at an edge): state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, fetch_cnt=0, fetch_fault=0, imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC. Reset mid-transaction abandons it; a late imem_resp_valid after reset is ignored because state is not WAIT.
- First rst_n-high edge: IDLE->REQ; imem_req_valid=1 in the following cycle.
- Request accepted at edge t -> WAIT from t; earliest response sampled at edge t+1 -> inst_valid=1 from t+1.
- Minimum loop with zero-wait memory, immediate inst_ready and npc_valid: REQ, WAIT, OUT, NPC = 4 cycles per instruction.
- inst_ready while inst_valid=0 has no effect; inst_valid held high indefinitely while inst_ready=0 (backpressure), data unchanged.
- fetch_cnt increments in the cycle after handshake edge, once per instruction.

## Test plan
- Reset release, imem_req_ready=1, respond next cycle with 32'h00000413, inst_ready=1, npc=32'h8000_0004 on first NPC cycle -> first request addr 32'h8000_0000; inst=32'h00000413, inst_pc=32'h8000_0000; second request addr 32'h8000_0004; fetch_cnt=1.
- Hold imem_req_ready=0 for 3 cycles, then 1 -> req_valid high and addr stable throughout; single WAIT entry; spurious imem_resp_valid pulse while in REQ ignored.
- Hold inst_ready=0 for 5 cycles with inst valid -> inst_valid stays 1, inst/inst_pc unchanged, fetch_cnt unchanged until handshake, then +1.
- npc=32'h8000_0006 -> fetch_fault=1, no further imem_req_valid; imem_resp_err=1 in WAIT -> same FAULT behaviour; rst_n low one cycle -> fault cleared, refetch from 32'h8000_0000.
- Preload fetch_cnt path by running 2^32 handshakes (or force to 32'hFFFF_FFFF) then one handshake -> fetch_cnt=0.
- Assert rst_n low while in WAIT, then deliver imem_resp_valid the cycle after release -> response ignored, fresh request to RESET_PC issued.
